// File: rtl/sample_framer.sv
// Packs one captured sample set into a 15-byte frame (sync, seq, flags, payload, CRC-8)
// and streams it byte by byte over a valid/ready handshake; counts samples dropped while busy.
module sample_framer #(
    parameter logic [7:0] SYNC_BYTE = 8'hA5
) (
    input  logic        clk,
    input  logic        arst_n,
    input  logic        smpl_valid,
    input  logic [31:0] smpl_osc0,
    input  logic [31:0] smpl_osc1,
    input  logic [19:0] smpl_temp,
    input  logic        smpl_halt,
    output logic        smpl_ready,
    output logic [7:0]  byte_data,
    output logic        byte_valid,
    input  logic        byte_ready,
    output logic        frame_done,
    output logic [7:0]  drop_cnt
);

    // state | meaning
    // IDLE  | waiting for a sample set, smpl_ready high
    // SEND  | streaming bytes 0..14, r_idx selects the byte on the wire
    // DONE  | one cycle: frame_done pulse, sequence number advances
    typedef enum logic [1:0] {ST_IDLE, ST_SEND, ST_DONE} state_t;

    localparam logic [3:0] LAST_IDX = 4'd14;

    state_t      r_state;
    state_t      w_state_nxt;
    logic [3:0]  r_idx;
    logic [7:0]  r_crc;
    logic [7:0]  r_seq;
    logic [7:0]  r_drop_cnt;
    logic        r_drop_flag;
    logic        r_drop_cap;
    logic [31:0] r_osc0;
    logic [31:0] r_osc1;
    logic [19:0] r_temp;
    logic        r_halt;

    logic        w_accept;
    logic        w_drop;
    logic        w_hs;
    logic [7:0]  w_byte;

    function automatic logic [7:0] f_crc8_upd(input logic [7:0] crc_in, input logic [7:0] data);
        logic [7:0] c;
        c = crc_in ^ data;
        for (int i = 0; i < 8; i++) begin
            c = c[7] ? ({c[6:0], 1'b0} ^ 8'h07) : {c[6:0], 1'b0};
        end
        return c;
    endfunction

    assign w_accept = smpl_valid & (r_state == ST_IDLE);
    assign w_drop   = smpl_valid & (r_state != ST_IDLE);
    assign w_hs     = byte_valid & byte_ready;
    assign drop_cnt = r_drop_cnt;

    always_comb begin
        w_byte = r_crc;
        case (r_idx)
            4'd0:    w_byte = SYNC_BYTE;
            4'd1:    w_byte = r_seq;
            4'd2:    w_byte = {r_halt, r_drop_cap, 6'b0};
            4'd3:    w_byte = r_osc0[7:0];
            4'd4:    w_byte = r_osc0[15:8];
            4'd5:    w_byte = r_osc0[23:16];
            4'd6:    w_byte = r_osc0[31:24];
            4'd7:    w_byte = r_osc1[7:0];
            4'd8:    w_byte = r_osc1[15:8];
            4'd9:    w_byte = r_osc1[23:16];
            4'd10:   w_byte = r_osc1[31:24];
            4'd11:   w_byte = r_temp[7:0];
            4'd12:   w_byte = r_temp[15:8];
            4'd13:   w_byte = {4'b0, r_temp[19:16]};
            default: w_byte = r_crc;
        endcase
    end

    always_comb begin
        w_state_nxt = r_state;
        smpl_ready  = 1'b0;
        byte_valid  = 1'b0;
        frame_done  = 1'b0;
        byte_data   = 8'h00;
        case (r_state)
            ST_IDLE: begin
                smpl_ready = 1'b1;
                if (smpl_valid) w_state_nxt = ST_SEND;
            end
            ST_SEND: begin
                byte_valid = 1'b1;
                byte_data  = w_byte;
                if (byte_ready && (r_idx == LAST_IDX)) w_state_nxt = ST_DONE;
            end
            ST_DONE: begin
                frame_done  = 1'b1;
                w_state_nxt = ST_IDLE;
            end
            default: w_state_nxt = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge arst_n) begin
        if (!arst_n) r_state <= ST_IDLE;
        else         r_state <= w_state_nxt;
    end

    always_ff @(posedge clk or negedge arst_n) begin
        if (!arst_n) begin
            r_idx       <= 4'd0;
            r_crc       <= 8'h00;
            r_seq       <= 8'h00;
            r_drop_cnt  <= 8'h00;
            r_drop_flag <= 1'b0;
            r_drop_cap  <= 1'b0;
            r_osc0      <= 32'h0;
            r_osc1      <= 32'h0;
            r_temp      <= 20'h0;
            r_halt      <= 1'b0;
        end else begin
            if (w_accept) begin
                r_idx       <= 4'd0;
                r_crc       <= 8'h00;
                r_osc0      <= smpl_osc0;
                r_osc1      <= smpl_osc1;
                r_temp      <= smpl_temp;
                r_halt      <= smpl_halt;
                r_drop_cap  <= r_drop_flag;
                r_drop_flag <= 1'b0;
            end
            if (w_drop) begin
                r_drop_flag <= 1'b1;
                if (r_drop_cnt != 8'hFF) r_drop_cnt <= r_drop_cnt + 8'd1;
            end
            if (w_hs) begin
                r_idx <= r_idx + 4'd1;
                // CRC covers seq through the last temp byte; sync and CRC itself are excluded
                if ((r_idx != 4'd0) && (r_idx != LAST_IDX)) r_crc <= f_crc8_upd(r_crc, w_byte);
            end
            if (r_state == ST_DONE) r_seq <= r_seq + 8'd1;
        end
    end

endmodule

// File: doc/sample_framer.md
SAMPLE_FRAMER -- requirements
Module: sample_framer

Interface
REQ-001 SHALL have parameter SYNC_BYTE, default 8'hA5, first byte of every frame.
REQ-002 SHALL have port clk  in  1  sole clock; all logic on rising edge.
REQ-003 SHALL have port arst_n  in  1  asynchronous active-low reset.
REQ-004 SHALL have port smpl_valid  in  1  one-cycle strobe, new sample set present.
REQ-005 SHALL have port smpl_osc0  in  32  2.5V ring-osc count.
REQ-006 SHALL have port smpl_osc1  in  32  3.3V ring-osc count.
REQ-007 SHALL have port smpl_temp  in  20  BMP280 raw temperature.
REQ-008 SHALL have port smpl_halt  in  1  osc halt flag at sample time.
REQ-009 SHALL have port smpl_ready  out  1  high only in IDLE; sample accepted when smpl_valid & smpl_ready.
REQ-010 SHALL have port byte_data  out  8  frame byte to byte-wide UART.
REQ-011 SHALL have port byte_valid  out  1  byte_data valid.
REQ-012 SHALL have port byte_ready  in  1  UART accepts byte_data when byte_valid & byte_ready.
REQ-013 SHALL have port frame_done  out  1  one-cycle pulse after last byte accepted.
REQ-014 SHALL have port drop_cnt  out  8  saturating count of dropped samples.

Function
REQ-015 SHALL implement states IDLE, SEND, DONE; IDLE->SEND on accept, SEND->DONE on handshake of byte 14, DONE->IDLE unconditionally next cycle.
REQ-016 SHALL capture all smpl_* inputs into internal registers on accept; later input changes SHALL NOT affect the frame.
REQ-017 SHALL emit 15-byte frame: b0 SYNC_BYTE; b1 seq; b2 flags {smpl_halt, drop_flag, 6'b0} MSB first; b3-b6 osc0 LSB first; b7-b10 osc1 LSB first; b11-b13 {4'b0, temp} LSB first; b14 CRC.
REQ-018 SHALL compute CRC-8, poly 0x07, init 0x00, no reflection, no final XOR, over b1..b13, updated on each handshake of those bytes.
REQ-019 SHALL assert byte_valid with b0 in the cycle after accept and hold byte_valid high and byte_data stable until handshake.
REQ-020 SHALL present the next byte in the cycle after a handshake with no idle cycle; byte_ready stall of any length SHALL be tolerated.
REQ-021 SHALL deassert byte_valid in DONE and IDLE.
REQ-022 SHALL pulse frame_done in DONE only.
REQ-023 SHALL increment seq (8 bit) in DONE, wrapping 255->0.
REQ-024 SHALL treat smpl_valid while smpl_ready low (SEND or DONE) as a drop: drop_cnt+1 saturating at 255, drop_flag set.
REQ-025 SHALL copy drop_flag into b2 on accept and clear drop_flag on that same edge; a drop cannot coincide with accept.
REQ-026 SHALL ignore byte_ready while byte_valid low.

Reset
REQ-027 SHALL on arst_n low, immediately and independent of clk: state IDLE, byte_valid 0, byte_data 0, frame_done 0, smpl_ready 1, seq 0, drop_cnt 0, drop_flag 0, CRC 0.
REQ-028 SHALL abort a frame in progress on reset without emitting further bytes; the first frame after reset SHALL start with seq 0.

Verification
REQ-029 Zero sample (osc0=osc1=0, temp=0, halt=0), byte_ready=1 -> A5 followed by fourteen 00, byte_valid high 15 consecutive cycles, frame_done 1 cycle later.
REQ-030 osc0=32'h12345678, osc1=32'hDEADBEEF, temp=20'hABCDE, halt=1 -> b2=80, b3-b6=78 56 34 12, b7-b10=EF BE AD DE, b11-b13=DE BC 0A, b14 matches CRC-8/0x07 model.
REQ-031 byte_ready toggled randomly -> byte sequence identical to REQ-030, byte_data never changes while byte_valid & !byte_ready.
REQ-032 smpl_valid pulsed 3 times during SEND -> drop_cnt=3, next frame b2 bit6=1, following frame bit6=0; 300 drops -> drop_cnt=255.
REQ-033 257 frames back-to-back -> b1 sequence 00..FF then 00.
REQ-034 arst_n low at byte 7 -> byte_valid 0 same cycle; next frame b1=00, drop_cnt=0.
